assoc_cache_ctrl: RTL and testbench

// Parametrised N-way set-associative, write-back, write-allocate cache with its own miss FSM.

---
 rtl/assoc_cache_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_assoc_cache_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/assoc_cache_ctrl.sv
// N-way set-associative write-back / write-allocate cache controller with age-based LRU
// replacement, dirty-line writeback and a req/ack line-wide memory port.
module assoc_cache_ctrl #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128,
    parameter int SETS   = 4,
    parameter int WAYS   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [1:0]        load_type,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [LINE_W-1:0] mem_rdata
);
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int AGE_W = WAY_W;

    typedef enum logic [1:0] {IDLE, TAG, WB, FILL} state_t;

    state_t state;

    logic [LINE_W-1:0] data_mem [SETS][WAYS];
    logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
    logic [WAYS-1:0]   valid    [SETS];
    logic [WAYS-1:0]   dirty    [SETS];
    logic [AGE_W-1:0]  age      [SETS][WAYS];

    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              req_write;
    logic [1:0]        req_type;
    logic [WAY_W-1:0]  victim;
    logic              filled;

    logic [ADDR_W-1:0] cur_addr;
    logic [TAG_W-1:0]  cur_tag, req_tag;
    logic [IDX_W-1:0]  cur_idx, req_idx;
    logic [OFF_W-1:0]  req_off;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [LINE_W-1:0] hit_line;
    logic              inv_found;
    logic [WAY_W-1:0]  inv_way, lru_way, pick;
    logic [AGE_W-1:0]  touch_age;

    function automatic logic [OFF_W-1:0] align_off(input logic [OFF_W-1:0] off,
                                                    input logic [1:0] ltype);
        case (ltype)
            2'd1:    return {off[OFF_W-1:1], 1'b0};
            2'd2:    return off;
            default: return {off[OFF_W-1:2], 2'b00};
        endcase
    endfunction

    function automatic logic [31:0] size_mask(input logic [1:0] ltype);
        case (ltype)
            2'd1:    return 32'h0000_FFFF;
            2'd2:    return 32'h0000_00FF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] read_lanes(input logic [LINE_W-1:0] line,
                                               input logic [OFF_W-1:0] off,
                                               input logic [1:0] ltype);
        logic [LINE_W-1:0] sh;
        sh = line >> {align_off(off, ltype), 3'b000};
        return sh[31:0] & size_mask(ltype);
    endfunction

    function automatic logic [LINE_W-1:0] merge_lanes(input logic [LINE_W-1:0] line,
                                                      input logic [OFF_W-1:0] off,
                                                      input logic [1:0] ltype,
                                                      input logic [31:0] wdata);
        logic [LINE_W-1:0] m, d;
        logic [OFF_W+2:0]  sa;
        sa = {align_off(off, ltype), 3'b000};
        m  = LINE_W'(size_mask(ltype)) << sa;
        d  = LINE_W'(wdata & size_mask(ltype)) << sa;
        return (line & ~m) | d;
    endfunction

    // Lookup runs on the incoming address while idle so the hit is known at acceptance.
    assign cur_addr = (state == IDLE) ? cpu_addr : req_addr;
    assign cur_tag  = cur_addr[ADDR_W-1 -: TAG_W];
    assign cur_idx  = cur_addr[OFF_W +: IDX_W];
    assign req_tag  = req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx  = req_addr[OFF_W +: IDX_W];
    assign req_off  = req_addr[OFF_W-1:0];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[cur_idx][w] && (tag_mem[cur_idx][w] == cur_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign hit_line = data_mem[cur_idx][hit_way];

    always_comb begin
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[req_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        for (int w = 1; w < WAYS; w++) begin
            if (age[req_idx][w] > age[req_idx][lru_way])
                lru_way = WAY_W'(w);
        end
        pick = inv_found ? inv_way : lru_way;
    end

    // A freshly filled way counts as the oldest, so every surviving way ages past it.
    assign touch_age = filled ? AGE_W'(WAYS - 1) : age[req_idx][hit_way];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            req_addr  <= '0;
            req_wdata <= '0;
            req_write <= 1'b0;
            req_type  <= '0;
            victim    <= '0;
            filled    <= 1'b0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                for (int w = 0; w < WAYS; w++) age[s][w] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    cpu_ready <= 1'b0;
                    if (cpu_req) begin
                        req_addr  <= cpu_addr;
                        req_wdata <= cpu_wdata;
                        req_write <= cpu_write;
                        req_type  <= load_type;
                        cpu_ready <= hit;
                        if (hit) cpu_rdata <= read_lanes(hit_line, cpu_addr[OFF_W-1:0], load_type);
                        state <= TAG;
                    end
                end
                TAG: begin
                    cpu_ready <= 1'b0;
                    if (hit) begin
                        for (int w = 0; w < WAYS; w++) begin
                            if (WAY_W'(w) == hit_way)
                                age[req_idx][w] <= '0;
                            else if (age[req_idx][w] < touch_age)
                                age[req_idx][w] <= age[req_idx][w] + 1'b1;
                        end
                        if (req_write) dirty[req_idx][hit_way] <= 1'b1;
                        filled <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        victim  <= pick;
                        mem_req <= 1'b1;
                        if (valid[req_idx][pick] && dirty[req_idx][pick]) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= {tag_mem[req_idx][pick], req_idx, {OFF_W{1'b0}}};
                            mem_wdata <= data_mem[req_idx][pick];
                            state     <= WB;
                        end else begin
                            mem_we   <= 1'b0;
                            mem_addr <= {req_tag, req_idx, {OFF_W{1'b0}}};
                            state    <= FILL;
                        end
                    end
                end
                WB: begin
                    if (mem_ack) begin
                        mem_we   <= 1'b0;
                        mem_addr <= {req_tag, req_idx, {OFF_W{1'b0}}};
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        mem_req                <= 1'b0;
                        valid[req_idx][victim] <= 1'b1;
                        dirty[req_idx][victim] <= 1'b0;
                        filled                 <= 1'b1;
                        cpu_ready              <= 1'b1;
                        cpu_rdata              <= read_lanes(mem_rdata, req_off, req_type);
                        state                  <= TAG;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line and tag storage carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (state == TAG && hit && req_write)
            data_mem[req_idx][hit_way] <= merge_lanes(hit_line, req_off, req_type, req_wdata);
        if (state == FILL && mem_ack) begin
            data_mem[req_idx][victim] <= mem_rdata;
            tag_mem[req_idx][victim]  <= req_tag;
        end
    end

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Randomised and directed bench for assoc_cache_ctrl against a recency-list cache model
// with a backing line memory.
module tb_assoc_cache_ctrl;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;
    localparam int SETS   = 4;
    localparam int WAYS   = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_write;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [1:0]        load_type;
    logic [31:0]       cpu_rdata;
    logic              cpu_ready;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [LINE_W-1:0] mem_rdata;

    always #5 clk = ~clk;

    assoc_cache_ctrl #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .SETS(SETS), .WAYS(WAYS)) dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_write(cpu_write),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .load_type(load_type),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    int cnt_cmp = 0;
    int cnt_err = 0;

    typedef struct {
        int unsigned       tag;
        logic [LINE_W-1:0] data;
        bit                dirty;
    } line_t;

    line_t             cq [SETS][$];   // most recently used first
    logic [LINE_W-1:0] bmem [int unsigned];
    int unsigned       seen_wb_addr, seen_fill_addr;
    logic [LINE_W-1:0] seen_wb_data;

    function automatic logic [LINE_W-1:0] mem_line(input int unsigned a);
        if (bmem.exists(a)) return bmem[a];
        return {a + 32'h3030_3030, a + 32'h2020_2020, a + 32'h1010_1010, ~a};
    endfunction

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) cq[s].delete();
    endtask

    task automatic model_access(input bit wr, input int unsigned addr, input logic [31:0] wd,
                                input logic [1:0] lt, output bit hit, output bit wb,
                                output int unsigned wb_a, output logic [LINE_W-1:0] wb_d,
                                output int unsigned fill_a, output logic [31:0] rd);
        int unsigned set  = (addr >> 4) & 3;
        int unsigned tag  = addr >> 6;
        int unsigned off  = addr & 15;
        int unsigned n    = (lt == 2'd2) ? 1 : (lt == 2'd1) ? 2 : 4;
        int unsigned base = (off / n) * n;
        int          idx  = -1;
        line_t       e, v;
        for (int i = 0; i < cq[set].size(); i++) if (cq[set][i].tag == tag) idx = i;
        hit = (idx >= 0); wb = 0; wb_a = 0; wb_d = '0; fill_a = 0;
        if (hit) begin
            e = cq[set][idx];
            cq[set].delete(idx);
        end else begin
            if (cq[set].size() == WAYS) begin
                v = cq[set].pop_back();
                if (v.dirty) begin
                    wb = 1; wb_a = (v.tag << 6) | (set << 4); wb_d = v.data;
                    bmem[wb_a] = v.data;
                end
            end
            fill_a = addr & ~32'hF;
            e.tag = tag; e.data = mem_line(fill_a); e.dirty = 0;
        end
        rd = '0;
        for (int b = 0; b < n; b++) rd |= 32'(e.data[(base + b) * 8 +: 8]) << (8 * b);
        if (wr) begin
            for (int b = 0; b < n; b++) e.data[(base + b) * 8 +: 8] = wd[8 * b +: 8];
            e.dirty = 1;
        end
        cq[set].push_front(e);
    endtask

    task automatic do_access(input bit wr, input int unsigned addr, input logic [31:0] wd,
                             input logic [1:0] lt, input int delay, input bit pulse,
                             output logic [31:0] got_rd);
        bit                exp_hit, exp_wb, done, got_wb, got_fill, open;
        int unsigned       wb_a, fill_a;
        logic [LINE_W-1:0] wb_d, s_wd;
        logic [31:0]       exp_rd, s_addr;
        logic              s_we;
        int                cyc, wcnt, ack_cyc, exp_lat;
        model_access(wr, addr, wd, lt, exp_hit, exp_wb, wb_a, wb_d, fill_a, exp_rd);
        cpu_req = 1; cpu_write = wr; cpu_addr = addr; cpu_wdata = wd; load_type = lt;
        @(negedge clk);
        cpu_req = 0;
        cyc = 0; done = 0; got_wb = 0; got_fill = 0; open = 0; wcnt = 0; ack_cyc = -10;
        got_rd = '0;
        while (!done && cyc < 200) begin
            if (cpu_ready) begin
                done = 1; got_rd = cpu_rdata;
                exp_lat = exp_hit ? 0 : ack_cyc + 1;
                cnt_cmp++;
                if (cyc !== exp_lat) begin
                    cnt_err++;
                    $display("FAIL ready_latency addr=%h got cycle %0d expected %0d", addr, cyc, exp_lat);
                end
                if (!wr) begin
                    cnt_cmp++;
                    if (cpu_rdata !== exp_rd) begin
                        cnt_err++;
                        $display("FAIL load_data addr=%h type=%0d got %h expected %h", addr, lt, cpu_rdata, exp_rd);
                    end
                end
            end else if (mem_req) begin
                if (!open) begin
                    open = 1; s_addr = mem_addr; s_we = mem_we; s_wd = mem_wdata;
                end else begin
                    cnt_cmp++;
                    if ({mem_addr, mem_we, mem_wdata} !== {s_addr, s_we, s_wd}) begin
                        cnt_err++;
                        $display("FAIL mem_stable got addr=%h we=%b expected addr=%h we=%b", mem_addr, mem_we, s_addr, s_we);
                    end
                end
                if (wcnt >= delay) begin
                    if (exp_wb && !got_wb) begin
                        got_wb = 1; seen_wb_addr = mem_addr; seen_wb_data = mem_wdata;
                        cnt_cmp++;
                        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, wb_a, wb_d}) begin
                            cnt_err++;
                            $display("FAIL writeback got we=%b addr=%h data=%h expected we=1 addr=%h data=%h", mem_we, mem_addr, mem_wdata, wb_a, wb_d);
                        end
                        mem_rdata = '0;
                    end else begin
                        cnt_cmp++;
                        if (got_fill || exp_hit || mem_we !== 1'b0 || mem_addr !== fill_a) begin
                            cnt_err++;
                            $display("FAIL fill_request got we=%b addr=%h expected we=0 addr=%h (hit=%0d)", mem_we, mem_addr, fill_a, exp_hit);
                        end
                        got_fill = 1; seen_fill_addr = mem_addr; ack_cyc = cyc;
                        mem_rdata = mem_line(fill_a);
                    end
                    mem_ack = 1; cpu_req = 0; open = 0; wcnt = 0;
                end else begin
                    wcnt++;
                    if (pulse) begin
                        cpu_req = ~cpu_req; cpu_addr = $urandom_range(0, 1023); cpu_write = $urandom_range(0, 1);
                    end
                end
            end
            @(negedge clk);
            mem_ack = 0;
            cyc++;
        end
        cpu_req = 0;
        if (!done) begin
            cnt_cmp++; cnt_err++;
            $display("FAIL timeout addr=%h got no cpu_ready expected one within 200 cycles", addr);
        end
        cnt_cmp++;
        if ({got_wb, got_fill} !== {exp_wb, !exp_hit}) begin
            cnt_err++;
            $display("FAIL mem_phases addr=%h got wb=%b fill=%b expected wb=%b fill=%b", addr, got_wb, got_fill, exp_wb, !exp_hit);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        cnt_cmp++;
        if ({cpu_ready, mem_req, mem_we} !== 3'b000) begin
            cnt_err++;
            $display("FAIL reset_ctrl got ready/req/we=%b expected 000", {cpu_ready, mem_req, mem_we});
        end
        cnt_cmp++;
        if (mem_addr !== '0 || cpu_rdata !== '0) begin
            cnt_err++;
            $display("FAIL reset_addr_rdata got mem_addr=%h rdata=%h expected 0 0", mem_addr, cpu_rdata);
        end
        cnt_cmp++;
        if (mem_wdata !== '0) begin
            cnt_err++;
            $display("FAIL reset_wdata got %h expected 0", mem_wdata);
        end
        reset = 1; model_clear();
        repeat (3) @(negedge clk);
        cnt_cmp++;
        if (mem_req !== 1'b0) begin
            cnt_err++;
            $display("FAIL idle_no_req got mem_req=%b expected 0", mem_req);
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        bmem[32'h80] = {32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h1122_3344};
        do_access(0, 32'h80, 0, 2'd0, 2, 0, rd);
        cnt_cmp++;
        if (rd !== 32'h1122_3344) begin cnt_err++; $display("FAIL first_load got %h expected 11223344", rd); end
        cnt_cmp++;
        if (seen_fill_addr !== 32'h80) begin cnt_err++; $display("FAIL first_fill_addr got %h expected 00000080", seen_fill_addr); end
        do_access(1, 32'h84, 32'hDEAD_BEEF, 2'd0, 0, 0, rd);
        do_access(0, 32'h84, 0, 2'd0, 0, 0, rd);
        cnt_cmp++;
        if (rd !== 32'hDEAD_BEEF) begin cnt_err++; $display("FAIL store_word got %h expected deadbeef", rd); end
        do_access(1, 32'h87, 32'h0000_00AA, 2'd2, 0, 0, rd);
        do_access(0, 32'h84, 0, 2'd0, 0, 0, rd);
        cnt_cmp++;
        if (rd !== 32'hAAAD_BEEF) begin cnt_err++; $display("FAIL store_byte got %h expected aaadbeef", rd); end
        do_access(0, 32'h86, 0, 2'd1, 0, 0, rd);
        cnt_cmp++;
        if (rd !== 32'h0000_AAAD) begin cnt_err++; $display("FAIL load_half got %h expected 0000aaad", rd); end
    endtask

    task automatic test_evict();
        logic [31:0] rd;
        do_access(0, 32'hC0, 0, 2'd0, 1, 0, rd);
        do_access(0, 32'h100, 0, 2'd0, 1, 0, rd);
        cnt_cmp++;
        if (seen_wb_addr !== 32'h80 || seen_wb_data[63:32] !== 32'hAAAD_BEEF) begin
            cnt_err++;
            $display("FAIL evict_wb got addr=%h word1=%h expected 00000080 aaadbeef", seen_wb_addr, seen_wb_data[63:32]);
        end
        cnt_cmp++;
        if (seen_fill_addr !== 32'h100) begin cnt_err++; $display("FAIL evict_fill got %h expected 00000100", seen_fill_addr); end
    endtask

    task automatic test_stall();
        logic [31:0] rd;
        do_access(1, 32'hC8, 32'h1234_5678, 2'd0, 0, 0, rd);
        do_access(0, 32'h100, 0, 2'd0, 0, 0, rd);
        do_access(0, 32'h140, 0, 2'd0, 7, 1, rd);
        cnt_cmp++;
        if (seen_wb_addr !== 32'hC0 || seen_wb_data[95:64] !== 32'h1234_5678) begin
            cnt_err++;
            $display("FAIL stall_wb got addr=%h word2=%h expected 000000c0 12345678", seen_wb_addr, seen_wb_data[95:64]);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd;
        for (int i = 0; i < 150; i++)
            do_access($urandom_range(0, 1), $urandom_range(0, 255), $urandom, 2'($urandom_range(0, 3)),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)), rd);
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] rd;
        bit          seen;
        reset = 0;
        @(negedge clk);
        reset = 1; model_clear();
        @(negedge clk);
        cpu_req = 1; cpu_write = 0; cpu_addr = 32'h300; load_type = 2'd0;
        @(negedge clk);
        cpu_req = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (mem_req) seen = 1; else @(negedge clk);
        end
        cnt_cmp++;
        if (!seen || mem_we !== 1'b0 || mem_addr !== 32'h300) begin
            cnt_err++;
            $display("FAIL pre_reset_fill got req=%b we=%b addr=%h expected 1 0 00000300", mem_req, mem_we, mem_addr);
        end
        repeat (3) @(negedge clk);
        #2 reset = 0;
        #1;
        cnt_cmp++;
        if ({mem_req, mem_we, cpu_ready} !== 3'b000) begin
            cnt_err++;
            $display("FAIL async_reset got req/we/ready=%b expected 000", {mem_req, mem_we, cpu_ready});
        end
        @(negedge clk);
        reset = 1; model_clear();
        @(negedge clk);
        do_access(0, 32'h80, 0, 2'd0, 1, 0, rd);
        cnt_cmp++;
        if (seen_fill_addr !== 32'h80) begin cnt_err++; $display("FAIL refill_addr got %h expected 00000080", seen_fill_addr); end
    endtask

    initial begin
        reset = 0; cpu_req = 0; cpu_write = 0; cpu_addr = '0; cpu_wdata = '0;
        load_type = '0; mem_ack = 0; mem_rdata = '0;
        seen_wb_addr = 0; seen_fill_addr = 0; seen_wb_data = '0;
        test_reset();
        test_basic();
        test_evict();
        test_stall();
        test_random();
        test_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_err);
        $finish;
    end
endmodule
